// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF) and data memory (DM).
// One access in flight at a time; ties go to the requester not granted last.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               owner_q, owner_nxt;
    logic               last_gnt_q, last_gnt_nxt;
    logic               acc_we_q, acc_we_nxt;
    logic               grant_dm;
    logic               mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic               if_ack_nxt, dm_ack_nxt;
    logic [DATA_W-1:0]  if_rdata_nxt, dm_rdata_nxt;

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= GNT_IF;
            last_gnt_q <= GNT_IF;
            acc_we_q   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            owner_q    <= owner_nxt;
            last_gnt_q <= last_gnt_nxt;
            acc_we_q   <= acc_we_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_ack     <= if_ack_nxt;
            dm_ack     <= dm_ack_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
        end
    end

    // Next state; mem strobe and acks are computed one cycle ahead so they leave a flop
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        owner_nxt     = owner_q;
        last_gnt_nxt  = last_gnt_q;
        acc_we_nxt    = acc_we_q;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_ack_nxt    = 1'b0;
        dm_ack_nxt    = 1'b0;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        grant_dm      = dm_req & (~if_req | (last_gnt_q == GNT_IF));

        case (state_q)
            S_IDLE: begin
                if (if_req | dm_req) begin
                    state_nxt    = S_ISSUE;
                    owner_nxt    = grant_dm;
                    last_gnt_nxt = grant_dm;
                    mem_en_nxt   = 1'b1;
                    if (grant_dm) begin
                        acc_we_nxt    = dm_we;
                        mem_we_nxt    = dm_we;
                        mem_addr_nxt  = dm_addr;
                        mem_wdata_nxt = dm_wdata;
                    end else begin
                        acc_we_nxt    = 1'b0;
                        mem_addr_nxt  = if_addr;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                cnt_nxt   = CNT_W'(MEM_LAT);
            end
            S_WAIT: begin
                // Count of 1 marks the cycle mem_rdata is valid
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = S_RESP;
                    cnt_nxt   = '0;
                    if (owner_q == GNT_DM) begin
                        dm_ack_nxt = 1'b1;
                        if (!acc_we_q) dm_rdata_nxt = mem_rdata;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 5) each with a latency-accurate memory model.
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic clk, rst;
    logic [2:0]       if_req, if_ack, if_stall, dm_req, dm_we, dm_ack, dm_stall, mem_en, mem_we;
    logic [2:0][31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    int tests;
    int fails;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];
    int unsigned cd [3];
    logic [31:0] pend [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
            mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
                .clk(clk), .rst(rst),
                .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]),
                .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
                .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]),
                .dm_wdata(dm_wdata[g]), .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]),
                .dm_stall(dm_stall[g]),
                .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
                .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : mem_default(a);
    endfunction

    // Memory: data valid exactly MEM_LAT cycles after mem_en, noise on every other cycle
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mem_en[g]) begin
                if (mem_we[g]) mem_arr[mem_addr[g]] = mem_wdata[g];
                if (lat_of(g) == 1) begin
                    mem_rdata[g] <= mem_read(mem_addr[g]);
                end else begin
                    cd[g]        <= lat_of(g) - 1;
                    pend[g]      <= mem_read(mem_addr[g]);
                    mem_rdata[g] <= $urandom;
                end
            end else if (cd[g] == 1) begin
                mem_rdata[g] <= pend[g];
                cd[g]        <= 0;
            end else begin
                if (cd[g] > 1) cd[g] <= cd[g] - 1;
                mem_rdata[g] <= $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_req = '0;
        dm_req = '0;
        dm_we  = '0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #50 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #10 rst = 1'b0;
        #10;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({mem_en[g], mem_we[g], if_ack[g], dm_ack[g], mem_addr[g], mem_wdata[g],
                 if_rdata[g], dm_rdata[g], if_stall[g], dm_stall[g]} !== '0) begin
                fails++;
                $display("FAIL reset_values inst%0d: got en=%b we=%b acks=%b%b addr=%h wd=%h ird=%h drd=%h, expected all 0",
                         g, mem_en[g], mem_we[g], if_ack[g], dm_ack[g], mem_addr[g], mem_wdata[g],
                         if_rdata[g], dm_rdata[g]);
            end
        end
        do_reset();
    endtask

    task automatic test_single_if_read();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h40;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp;
            if (k == 5) if_req[0] = 1'b0;
            #1;
            exp = {k == 1, k == 4, k <= 3};
            tests++;
            if ({mem_en[0], if_ack[0], if_stall[0]} !== exp) begin
                fails++;
                $display("FAIL single_if cyc%0d {en,ack,stall}: got %b expected %b", k,
                         {mem_en[0], if_ack[0], if_stall[0]}, exp);
            end
            if (k == 1) begin
                tests++;
                if ({mem_addr[0], mem_we[0]} !== {32'h40, 1'b0}) begin
                    fails++;
                    $display("FAIL single_if issue: got addr=%h we=%b expected addr=00000040 we=0",
                             mem_addr[0], mem_we[0]);
                end
            end
            if (k == 4) begin
                tests++;
                if (if_rdata[0] !== 32'h2008000A) begin
                    fails++;
                    $display("FAIL single_if rdata: got %h expected 2008000a", if_rdata[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_addr[0] = 32'h44;
        dm_addr[0] = 32'h100;
        dm_we[0]   = 1'b0;
        if_req[0]  = 1'b1;
        dm_req[0]  = 1'b1;
        for (int k = 0; k < 11; k++) begin
            logic [4:0] exp;
            if (k == 5)  dm_req[0] = 1'b0;
            if (k == 10) if_req[0] = 1'b0;
            #1;
            exp = {k == 1 || k == 6, k == 4, k == 9, k <= 3, k <= 8};
            tests++;
            if ({mem_en[0], dm_ack[0], if_ack[0], dm_stall[0], if_stall[0]} !== exp) begin
                fails++;
                $display("FAIL simultaneous cyc%0d {en,dack,iack,dstall,istall}: got %b expected %b", k,
                         {mem_en[0], dm_ack[0], if_ack[0], dm_stall[0], if_stall[0]}, exp);
            end
            if (k == 1 || k == 6) begin
                tests++;
                if (mem_addr[0] !== ((k == 1) ? 32'h100 : 32'h44)) begin
                    fails++;
                    $display("FAIL simultaneous addr cyc%0d: got %h expected %h", k, mem_addr[0],
                             (k == 1) ? 32'h100 : 32'h44);
                end
            end
            if (k == 4) begin
                tests++;
                if (dm_rdata[0] !== mem_read(32'h100)) begin
                    fails++;
                    $display("FAIL simultaneous dm_rdata: got %h expected %h", dm_rdata[0], mem_read(32'h100));
                end
            end
            if (k == 9) begin
                tests++;
                if (if_rdata[0] !== mem_read(32'h44)) begin
                    fails++;
                    $display("FAIL simultaneous if_rdata: got %h expected %h", if_rdata[0], mem_read(32'h44));
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        do_reset();
        if_addr[0] = 32'h80;
        dm_addr[0] = 32'h180;
        dm_we[0]   = 1'b0;
        if_req[0]  = 1'b1;
        dm_req[0]  = 1'b1;
        for (int k = 0; k < 30; k++) begin
            logic e_if, e_dm;
            #1;
            e_dm = (k % 5 == 4) && ((k / 5) % 2 == 0);
            e_if = (k % 5 == 4) && ((k / 5) % 2 == 1);
            tests++;
            if ({if_ack[0], dm_ack[0]} !== {e_if, e_dm}) begin
                fails++;
                $display("FAIL contention cyc%0d {if_ack,dm_ack}: got %b%b expected %b%b", k,
                         if_ack[0], dm_ack[0], e_if, e_dm);
            end
            if (e_dm || e_if) begin
                tests++;
                if ((e_dm ? dm_rdata[0] : if_rdata[0]) !== mem_read(e_dm ? 32'h180 : 32'h80)) begin
                    fails++;
                    $display("FAIL contention rdata cyc%0d: got %h expected %h", k,
                             e_dm ? dm_rdata[0] : if_rdata[0], mem_read(e_dm ? 32'h180 : 32'h80));
                end
            end
            tick();
        end
        if_req[0] = 1'b0;
        dm_req[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_dm_write();
        dm_req[0]   = 1'b1;
        dm_we[0]    = 1'b1;
        dm_addr[0]  = 32'h200;
        dm_wdata[0] = 32'hDEADBEEF;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp;
            if (k == 5) begin
                dm_req[0] = 1'b0;
                dm_we[0]  = 1'b0;
            end
            #1;
            exp = {k == 1, k == 1, k == 4};
            tests++;
            if ({mem_en[0], mem_we[0], dm_ack[0]} !== exp) begin
                fails++;
                $display("FAIL dm_write cyc%0d {en,we,ack}: got %b expected %b", k,
                         {mem_en[0], mem_we[0], dm_ack[0]}, exp);
            end
            if (k == 1) begin
                tests++;
                if ({mem_addr[0], mem_wdata[0]} !== {32'h200, 32'hDEADBEEF}) begin
                    fails++;
                    $display("FAIL dm_write payload: got addr=%h wd=%h expected 00000200/deadbeef",
                             mem_addr[0], mem_wdata[0]);
                end
            end
            // Last DM read before this write was the contention run at 0x180
            tests++;
            if (dm_rdata[0] !== mem_read(32'h180)) begin
                fails++;
                $display("FAIL dm_write rdata_kept cyc%0d: got %h expected %h", k, dm_rdata[0], mem_read(32'h180));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h48;
        tick();
        #1;
        tests++;
        if (mem_en[0] !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_wait issue: got mem_en=%b expected 1", mem_en[0]);
        end
        tick();
        rst       = 1'b0;
        if_req[0] = 1'b0;
        #1;
        tests++;
        if ({mem_en[0], mem_we[0], if_ack[0], dm_ack[0], mem_addr[0], mem_wdata[0],
             if_rdata[0], dm_rdata[0]} !== '0) begin
            fails++;
            $display("FAIL rst_mid_wait zero: got en=%b we=%b acks=%b%b addr=%h wd=%h ird=%h drd=%h expected all 0",
                     mem_en[0], mem_we[0], if_ack[0], dm_ack[0], mem_addr[0], mem_wdata[0],
                     if_rdata[0], dm_rdata[0]);
        end
        @(posedge clk);
        #50 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests++;
            if ({mem_en[0], if_ack[0], dm_ack[0]} !== 3'b000) begin
                fails++;
                $display("FAIL rst_mid_wait quiet cyc%0d: got {en,iack,dack}=%b expected 000", k,
                         {mem_en[0], if_ack[0], dm_ack[0]});
            end
            tick();
        end
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h4C;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) if_req[0] = 1'b0;
            #1;
            tests++;
            if ({mem_en[0], if_ack[0]} !== {k == 1, k == 4}) begin
                fails++;
                $display("FAIL rst_mid_wait fresh cyc%0d {en,ack}: got %b%b expected %b%b", k,
                         mem_en[0], if_ack[0], k == 1, k == 4);
            end
            if (k == 4) begin
                tests++;
                if (if_rdata[0] !== mem_read(32'h4C)) begin
                    fails++;
                    $display("FAIL rst_mid_wait rdata: got %h expected %h", if_rdata[0], mem_read(32'h4C));
                end
            end
            tick();
        end
    endtask

    task automatic test_latency_sweep();
        if_addr[1] = 32'h60;
        if_addr[2] = 32'h64;
        if_req[1]  = 1'b1;
        if_req[2]  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) if_req[1] = 1'b0;
            if (k == 8) if_req[2] = 1'b0;
            #1;
            tests++;
            if ({mem_en[1], if_ack[1]} !== {k == 1, k == 3}) begin
                fails++;
                $display("FAIL lat1 cyc%0d {en,ack}: got %b%b expected %b%b", k, mem_en[1], if_ack[1], k == 1, k == 3);
            end
            tests++;
            if ({mem_en[2], if_ack[2]} !== {k == 1, k == 7}) begin
                fails++;
                $display("FAIL lat5 cyc%0d {en,ack}: got %b%b expected %b%b", k, mem_en[2], if_ack[2], k == 1, k == 7);
            end
            if (k == 3 || k == 7) begin
                tests++;
                if (if_rdata[(k == 3) ? 1 : 2] !== mem_read((k == 3) ? 32'h60 : 32'h64)) begin
                    fails++;
                    $display("FAIL lat_sweep rdata cyc%0d: got %h expected %h", k,
                             if_rdata[(k == 3) ? 1 : 2], mem_read((k == 3) ? 32'h60 : 32'h64));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int          free_at, en_c, ack_c;
        bit          last_dm, own_dm, own_we, done_if, done_dm;
        logic [31:0] e_addr, e_wdata, e_rd, e_if_rd, e_dm_rd;
        logic [1:0]  e_ack;
        free_at = 0; en_c = -1; ack_c = -1;
        last_dm = 1'b0; own_dm = 1'b0; own_we = 1'b0; done_if = 1'b0; done_dm = 1'b0;
        e_addr = '0; e_wdata = '0; e_rd = '0; e_if_rd = '0; e_dm_rd = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            // Requesters: hold through the ack cycle, then drop or re-request
            if (done_if) begin
                if_req[0]  = ($urandom_range(0, 1) == 1);
                if_addr[0] = 32'h1000 + ($urandom_range(0, 7) << 2);
                done_if    = 1'b0;
            end else if (!if_req[0] && $urandom_range(0, 2) == 0) begin
                if_req[0]  = 1'b1;
                if_addr[0] = 32'h1000 + ($urandom_range(0, 7) << 2);
            end
            if (done_dm || (!dm_req[0] && $urandom_range(0, 2) == 0)) begin
                dm_req[0]   = done_dm ? ($urandom_range(0, 1) == 1) : 1'b1;
                dm_we[0]    = ($urandom_range(0, 1) == 1);
                dm_addr[0]  = 32'h1000 + ($urandom_range(0, 7) << 2);
                dm_wdata[0] = $urandom;
                done_dm     = 1'b0;
            end
            // Reference: one access per MEM_LAT+3 cycles, ties to the one not granted last
            if (c >= free_at && (if_req[0] || dm_req[0])) begin
                own_dm  = dm_req[0] && (!if_req[0] || !last_dm);
                last_dm = own_dm;
                own_we  = own_dm && dm_we[0];
                e_addr  = own_dm ? dm_addr[0] : if_addr[0];
                e_wdata = dm_wdata[0];
                en_c    = c + 1;
                ack_c   = c + 4;
                free_at = c + 5;
                if (own_we) exp_mem[e_addr] = e_wdata;
                else e_rd = exp_mem.exists(e_addr) ? exp_mem[e_addr] : mem_default(e_addr);
            end
            #1;
            e_ack = (c == ack_c) ? (own_dm ? 2'b01 : 2'b10) : 2'b00;
            if (c == ack_c && !own_we) begin
                if (own_dm) e_dm_rd = e_rd;
                else        e_if_rd = e_rd;
            end
            tests++;
            if (c == en_c) begin
                if ({mem_en[0], mem_we[0], mem_addr[0], own_we ? mem_wdata[0] : e_wdata} !==
                    {1'b1, own_we, e_addr, e_wdata}) begin
                    fails++;
                    $display("FAIL rand_issue cyc%0d: got en=%b we=%b addr=%h wd=%h expected 1/%b/%h/%h", c,
                             mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], own_we, e_addr, e_wdata);
                end
            end else if ({mem_en[0], mem_we[0]} !== 2'b00) begin
                fails++;
                $display("FAIL rand_idle_bus cyc%0d: got en=%b we=%b expected 0/0", c, mem_en[0], mem_we[0]);
            end
            tests++;
            if ({if_ack[0], dm_ack[0]} !== e_ack) begin
                fails++;
                $display("FAIL rand_ack cyc%0d {if,dm}: got %b%b expected %b", c, if_ack[0], dm_ack[0], e_ack);
            end
            tests++;
            if ({if_rdata[0], dm_rdata[0]} !== {e_if_rd, e_dm_rd}) begin
                fails++;
                $display("FAIL rand_rdata cyc%0d: got if=%h dm=%h expected if=%h dm=%h", c,
                         if_rdata[0], dm_rdata[0], e_if_rd, e_dm_rd);
            end
            tests++;
            if ({if_stall[0], dm_stall[0]} !== {if_req[0] & ~e_ack[1], dm_req[0] & ~e_ack[0]}) begin
                fails++;
                $display("FAIL rand_stall cyc%0d: got %b%b expected %b%b", c, if_stall[0], dm_stall[0],
                         if_req[0] & ~e_ack[1], dm_req[0] & ~e_ack[0]);
            end
            if (e_ack[1]) done_if = 1'b1;
            if (e_ack[0]) done_dm = 1'b1;
            tick();
        end
        if_req[0] = 1'b0;
        dm_req[0] = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        if_req   = '0;
        dm_req   = '0;
        dm_we    = '0;
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        for (int g = 0; g < 3; g++) cd[g] = 0;
        mem_arr[32'h40] = 32'h2008000A;
        exp_mem[32'h40] = 32'h2008000A;
        test_reset();
        test_single_if_read();
        test_simultaneous();
        test_contention();
        test_dm_write();
        test_reset_mid_wait();
        test_latency_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM). Each requester uses a req/ack handshake. The arbiter issues one access at a time to the memory, waits the fixed memory latency, and returns read data with a one-cycle ack. It sits between the Processor's fetch/memory stages and the memory model, and drives the stall signals that freeze the pipeline while an access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  IF access request; held until if_ack
- if_addr  input  ADDR_W  IF read address; stable while if_req
- if_ack  output  1  one-cycle pulse; if_rdata valid
- if_rdata  output  DATA_W  IF read data, registered
- if_stall  output  1  if_req & ~if_ack (combinational)
- dm_req  input  1  DM access request; held until dm_ack
- dm_we  input  1  DM write enable; stable while dm_req
- dm_addr  input  ADDR_W  DM address
- dm_wdata  input  DATA_W  DM write data
- dm_ack  output  1  one-cycle pulse; dm_rdata valid (reads)
- dm_rdata  output  DATA_W  DM read data, registered
- dm_stall  output  1  dm_req & ~dm_ack (combinational)
- mem_en  output  1  memory access strobe, one cycle per access
- mem_we  output  1  memory write enable, valid with mem_en
- mem_addr  output  ADDR_W  memory address, valid with mem_en
- mem_wdata  output  DATA_W  memory write data, valid with mem_en
- mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States:
  - IDLE → ISSUE when any request is sampled high.
  - ISSUE → WAIT.
  - WAIT → RESP when the latency counter expires.
  - RESP → IDLE.
- IDLE grant selection: if only one requester is active, grant it. If both are active, grant the one not recorded in the last_gnt register. On the transition, latch the owner, address, we and wdata of the granted request, and update last_gnt.
- ISSUE: mem_en=1, and mem_we/mem_addr/mem_wdata are driven from the latched values.
- WAIT: the counter loads MEM_LAT in ISSUE and decrements each WAIT cycle. On the cycle the counter reaches 1, mem_rdata is valid and is captured into the owner's rdata register. The state then moves to RESP.
- RESP: the owner's ack is 1 for exactly one cycle. For writes the ack is still returned; rdata is unchanged.
- Requests seen in RESP are ignored, because the owner still holds req during the ack cycle. New grants occur only in IDLE.
- The non-granted requester waits with its stall high. There is no queue depth beyond one per requester.
- Dropping req mid-transaction is illegal. The arbiter completes the access on its latched values and still pulses ack.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - mem_en, mem_we, if_ack and dm_ack go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - last_gnt goes to IF, so the first tie is won by DM.
  - An in-flight access is abandoned and no ack is issued.

## Timing
- All outputs are registered except if_stall and dm_stall.
- Request sampled in cycle t: mem_en in t+1, mem_rdata valid in t+1+MEM_LAT, ack in t+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles.
- The earliest next grant is sampled in the cycle after the ack (IDLE). Back-to-back accesses from one requester are MEM_LAT+3 cycles apart.
- With both requesters held high continuously, grants alternate DM, IF, DM, … with period MEM_LAT+3.
- rst deassertion is synchronized by the bench to #50 after a posedge. The first request is sampled at the next posedge.

## Test plan
- MEM_LAT=2 single IF read:
  - Stimulus: if_req=1, if_addr=0x00000040 at cycle 0; memory returns 0x2008000A.
  - Required: mem_en=1 with mem_addr=0x40 and mem_we=0 in cycle 1; if_ack=1 with if_rdata=0x2008000A in cycle 4; if_stall high in cycles 0–3.
- Simultaneous first requests after reset:
  - Stimulus: if_req and dm_req raised in the same cycle, dm_addr=0x100.
  - Required: DM is served first (mem_addr=0x100 in cycle 1, dm_ack in cycle 4); IF is issued in cycle 6; if_ack in cycle 9.
- Sustained contention:
  - Stimulus: both requests held for 6 accesses.
  - Required: ack order DM, IF, DM, IF, DM, IF; exactly one ack per 5 cycles; no cycle with both acks.
- DM write:
  - Stimulus: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF.
  - Required: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF for exactly one cycle; dm_ack 3 cycles later; dm_rdata unchanged.
- Reset mid-WAIT:
  - Stimulus: assert rst=0 one cycle after mem_en.
  - Required: all outputs read 0 immediately; no ack after release; a fresh if_req completes normally with latency 4.
- Latency parameter sweep:
  - Stimulus: MEM_LAT=1 and MEM_LAT=5 with single IF reads.
  - Required: ack arrives 3 and 7 cycles after the request, respectively, with the correct captured data.
